// File: rtl/tdes_pkg.sv
// tdes_pkg: sequencer states, round-core mode codes and the per-pass key schedule for 3DES
package tdes_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, PASS, DONE} state_e;
    localparam logic [2:0] CLR_MODE = 3'b100;
    localparam logic [2:0] RUN_MODE = 3'b000;
    localparam int BEATS = 4;
    localparam logic [1:0] K1 = 2'd0;
    localparam logic [1:0] K2 = 2'd1;
    localparam logic [1:0] K3 = 2'd2;
    typedef struct packed {
        logic [1:0] sel;
        logic       rev;
    } key_cfg_t;
    // E-D-E walks K1..K3 forward, D-E-D walks K3..K1; direction flips every pass
    function automatic key_cfg_t pass_key(input logic dec, input logic single, input logic [1:0] p);
        key_cfg_t k;
        k.sel = single ? K1 : (p == 2'd1) ? K2 : (dec ^ p[1]) ? K3 : K1;
        k.rev = single ? dec : dec ^ p[0];
        return k;
    endfunction
endpackage

// File: rtl/tdes_pass_sequencer.sv
// tdes_pass_sequencer: runs a 4-beat DES round core three times (E-D-E / D-E-D) or once per block,
// feeding each half-swapped pass result back in and handing the final block out on valid/ready.
module tdes_pass_sequencer
    import tdes_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic        in_decrypt,
    input  logic        in_single,
    input  logic        keys_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        core_enable,
    output logic [2:0]  core_mode,
    output logic [63:0] core_block,
    input  logic        core_ready,
    input  logic [63:0] core_out,
    output logic [1:0]  key_sel,
    output logic        key_rev,
    output logic        seq_err
);
    state_e      state_q, state_d;
    logic [63:0] blk_q, blk_d;
    logic [63:0] fb_q, fb_d;
    logic        dec_q, dec_d;
    logic        sgl_q, sgl_d;
    logic [1:0]  p_q, p_d;
    logic [1:0]  b_q, b_d;
    key_cfg_t    key_q, key_d;
    logic        err_q, err_d;
    logic        last_beat;
    logic        last_pass;

    assign last_beat = (state_q == PASS) && (b_q == 2'(BEATS - 1));
    assign last_pass = sgl_q ? (p_q == 2'd0) : (p_q == 2'd2);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            fb_q    <= '0;
            dec_q   <= 1'b0;
            sgl_q   <= 1'b0;
            p_q     <= '0;
            b_q     <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            fb_q    <= fb_d;
            dec_q   <= dec_d;
            sgl_q   <= sgl_d;
            p_q     <= p_d;
            b_q     <= b_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        fb_d    = fb_q;
        dec_d   = dec_q;
        sgl_d   = sgl_q;
        p_d     = p_q;
        b_d     = b_q;
        key_d   = key_q;
        // the core may only report ready on the closing beat of a pass
        err_d   = err_q | (core_ready != last_beat);
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    blk_d   = in_block;
                    dec_d   = in_decrypt;
                    sgl_d   = in_single;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                p_d     = '0;
                b_d     = '0;
                key_d   = pass_key(dec_q, sgl_q, 2'd0);
                state_d = PASS;
            end
            PASS: begin
                b_d = b_q + 2'd1;
                if (last_beat) begin
                    fb_d = {core_out[31:0], core_out[63:32]};
                    b_d  = '0;
                    if (last_pass) begin
                        state_d = DONE;
                    end else begin
                        p_d   = p_q + 2'd1;
                        key_d = pass_key(dec_q, sgl_q, p_q + 2'd1);
                    end
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = n_rst && keys_valid && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_block   = fb_q;
    assign core_enable = (state_q == PASS);
    assign core_mode   = (state_q == CLEAR) ? CLR_MODE : RUN_MODE;
    assign core_block  = (p_q == 2'd0) ? blk_q : fb_q;
    assign key_sel     = key_q.sel;
    assign key_rev     = key_q.rev;
    assign seq_err     = err_q;
endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// tb_tdes_pass_sequencer: drives the sequencer against a behavioural DES round-core model and
// checks every block against a block-level 3DES reference built from a plain DES function.
module tb_tdes_pass_sequencer;
    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam bit [3:0] SBOX[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};
    localparam logic [2:0] ENC_S[3] = '{3'b000, 3'b011, 3'b100};
    localparam logic [2:0] DEC_S[3] = '{3'b101, 3'b010, 3'b001};
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_block = '0;
    logic        in_decrypt = 1'b0;
    logic        in_single = 1'b0;
    logic        keys_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_block;
    logic        core_enable;
    logic [2:0]  core_mode;
    logic [63:0] core_block;
    logic        core_ready;
    logic [63:0] core_out;
    logic [1:0]  key_sel;
    logic        key_rev;
    logic        seq_err;

    logic [63:0] keys[3];
    logic [1:0]  ccnt = 2'd0;
    logic [63:0] cres = '0;
    logic        inj = 1'b0;
    logic        exp_err = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    tdes_pass_sequencer dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_decrypt(in_decrypt), .in_single(in_single), .keys_valid(keys_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .core_enable(core_enable), .core_mode(core_mode), .core_block(core_block),
        .core_ready(core_ready), .core_out(core_out), .key_sel(key_sel), .key_rev(key_rev),
        .seq_err(seq_err)
    );

    function automatic logic [63:0] des(input logic [63:0] key, input logic dec, input logic [63:0] blk);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [47:0] e;
        logic [63:0] ip, pre, o;
        logic [31:0] l, r, t, f, s;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < SH_T[n]; k++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ ks[dec ? 15 - n : n];
            for (int j = 0; j < 8; j++) begin
                six = e[47-6*j -: 6];
                row = int'({six[5], six[0]});
                col = int'(six[4:1]);
                s[31-4*j -: 4] = SBOX[j*64 + row*16 + col];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) o[63-i] = pre[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] tdes_ref(input logic [63:0] x, input logic dec, input logic sgl);
        if (sgl) return des(keys[0], dec, x);
        if (dec) return des(keys[0], 1'b1, des(keys[1], 1'b0, des(keys[2], 1'b1, x)));
        return des(keys[2], 1'b0, des(keys[1], 1'b1, des(keys[0], 1'b0, x)));
    endfunction

    // Round core stand-in: latches its block on the first beat, reports {L16,R16} (unswapped) on beat 3
    always @(posedge clk) begin
        if (core_mode == 3'b100) begin
            ccnt <= 2'd0;
        end else if (core_enable) begin
            if (ccnt == 2'd0) begin
                logic [63:0] res;
                res = des(keys[key_sel], key_rev, core_block);
                cres <= {res[31:0], res[63:32]};
            end
            ccnt <= ccnt + 2'd1;
        end
    end
    assign core_ready = (ccnt == 2'd3) | inj;
    assign core_out   = cres;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_block", out_block, 64'd0);
        check("rst_core_enable", 64'(core_enable), 64'd0);
        check("rst_core_mode", 64'(core_mode), 64'd0);
        check("rst_core_block", core_block, 64'd0);
        check("rst_key_sel", 64'(key_sel), 64'd0);
        check("rst_key_rev", 64'(key_rev), 64'd0);
        check("rst_seq_err", 64'(seq_err), 64'd0);
    endtask

    task automatic run_block(input logic [63:0] blk, input logic dec, input logic sgl, input int hold,
                             input int inj_at, input int rst_at, output logic [63:0] res);
        logic [63:0] exp;
        logic [2:0]  ek;
        int          n, lat, en, pi;
        res = '0;
        exp = tdes_ref(blk, dec, sgl);
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_block = blk;
        in_decrypt = dec;
        in_single = sgl;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_block = {$urandom(), $urandom()};
        in_decrypt = 1'($urandom());
        in_single = 1'($urandom());
        if (inj_at != 0) exp_err = 1'b1;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        check("clear_mode", 64'({core_enable, core_mode}), 64'({1'b0, 3'b100}));
        lat = 1;
        en = 0;
        while (!out_valid && lat < 40) begin
            inj = (inj_at != 0) && (lat == inj_at);
            if (core_enable) begin
                pi = en / 4;
                ek = sgl ? {2'd0, dec} : (pi > 2) ? 3'b111 : dec ? DEC_S[pi] : ENC_S[pi];
                check("key_sched", 64'({key_sel, key_rev}), 64'(ek));
                en++;
            end
            if (lat == rst_at) begin
                n_rst = 1'b0;
                #1;
                check_reset();
                @(negedge clk);
                n_rst = 1'b1;
                exp_err = 1'b0;
                return;
            end
            @(negedge clk);
            lat++;
        end
        inj = 1'b0;
        res = out_block;
        check("latency", 64'(lat), sgl ? 64'd6 : 64'd14);
        check("enable_cycles", 64'(en), sgl ? 64'd4 : 64'd12);
        check("out_block", out_block, exp);
        check("seq_err", 64'(seq_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'({out_valid, in_ready}), 64'(2'b10));
            check("hold_block", out_block, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_rise", 64'(in_ready), 64'(keys_valid));
    endtask

    initial begin
        logic [63:0] res;
        logic        dec, sgl;
        keys[0] = KAT_KEY;
        keys[1] = KAT_KEY;
        keys[2] = KAT_KEY;
        keys_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_reset();
        keys_valid = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        check("in_ready_nokeys", 64'(in_ready), 64'd0);
        keys_valid = 1'b1;
        #1;
        check("in_ready_keys", 64'(in_ready), 64'd1);

        run_block(KAT_PT, 1'b0, 1'b0, 0, 0, 0, res);
        check("kat_encrypt", res, KAT_CT);
        run_block(KAT_CT, 1'b1, 1'b0, 0, 0, 0, res);
        check("kat_decrypt", res, KAT_PT);
        run_block(KAT_PT, 1'b0, 1'b1, 0, 0, 0, res);
        check("kat_single", res, KAT_CT);
        run_block(KAT_PT, 1'b0, 1'b0, 10, 0, 0, res);
        run_block(KAT_PT, 1'b0, 1'b0, 0, 8, 0, res);
        check("err_sticky_out", res, KAT_CT);
        @(negedge clk);
        check("err_sticky_idle", 64'(seq_err), 64'd1);
        run_block(KAT_CT, 1'b1, 1'b0, 0, 0, 11, res);
        run_block(KAT_CT, 1'b1, 1'b0, 0, 0, 0, res);
        check("after_reset", res, KAT_PT);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) keys[k] = {$urandom(), $urandom()};
            dec = 1'($urandom());
            sgl = ($urandom_range(0, 3) == 0);
            run_block({$urandom(), $urandom()}, dec, sgl, int'($urandom_range(0, 3)), 0, 0, res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
